// File: rtl/twiddle_cmult_pipe.sv
// Pipelined complex multiply dout = din * W (or din * conj(W)), rounding and saturation to DATA_W.
// Latency 3 cycles, 1 sample/cycle; a held output (out_valid && !out_ready) freezes every stage.
module twiddle_cmult_pipe #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 8,
  parameter int TW_FRAC = 6,
  parameter int ROUND   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din_re,
  input  logic [DATA_W-1:0] din_im,
  input  logic [TW_W-1:0]   w_re,
  input  logic [TW_W-1:0]   w_im,
  input  logic              conj,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout_re,
  output logic [DATA_W-1:0] dout_im,
  output logic              sat
);

  localparam int PW    = DATA_W + TW_W;
  localparam int SW    = PW + 1;
  localparam int RND_I = (ROUND != 0) ? (1 << (TW_FRAC - 1)) : 0;

  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (DATA_W - 1)));

  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] val;
  } sat_res_t;

  logic advance;

  logic                     s1_vld;
  logic                     s1_conj;
  logic signed [DATA_W-1:0] s1_a;
  logic signed [DATA_W-1:0] s1_b;
  logic signed [TW_W-1:0]   s1_c;
  logic signed [TW_W-1:0]   s1_d;

  logic                 s2_vld;
  logic                 s2_conj;
  logic signed [PW-1:0] s2_ac;
  logic signed [PW-1:0] s2_bd;
  logic signed [PW-1:0] s2_ad;
  logic signed [PW-1:0] s2_bc;

  logic signed [SW-1:0] re_sum;
  logic signed [SW-1:0] im_sum;
  logic signed [SW-1:0] re_shf;
  logic signed [SW-1:0] im_shf;
  sat_res_t             re_res;
  sat_res_t             im_res;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_conj <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
      s1_d    <= '0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_conj <= conj;
      s1_a    <= $signed(din_re);
      s1_b    <= $signed(din_im);
      s1_c    <= $signed(w_re);
      s1_d    <= $signed(w_im);
    end
  end

  // Size casts sign-extend before multiplying so the full product is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_conj <= 1'b0;
      s2_ac   <= '0;
      s2_bd   <= '0;
      s2_ad   <= '0;
      s2_bc   <= '0;
    end else if (advance) begin
      s2_vld  <= s1_vld;
      s2_conj <= s1_conj;
      s2_ac   <= PW'(s1_a) * PW'(s1_c);
      s2_bd   <= PW'(s1_b) * PW'(s1_d);
      s2_ad   <= PW'(s1_a) * PW'(s1_d);
      s2_bc   <= PW'(s1_b) * PW'(s1_c);
    end
  end

  function automatic sat_res_t saturate(input logic signed [SW-1:0] v);
    sat_res_t r;
    if (v > SAT_MAX) begin
      r.ovf = 1'b1;
      r.val = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      r.ovf = 1'b1;
      r.val = SAT_MIN[DATA_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.val = v[DATA_W-1:0];
    end
    return r;
  endfunction

  // Shifting the whole sum keeps the high bits for the range check.
  always_comb begin
    re_sum = '0;
    im_sum = '0;
    if (s2_conj) begin
      re_sum = SW'(s2_ac) + SW'(s2_bd);
      im_sum = SW'(s2_bc) - SW'(s2_ad);
    end else begin
      re_sum = SW'(s2_ac) - SW'(s2_bd);
      im_sum = SW'(s2_bc) + SW'(s2_ad);
    end
    re_shf = (re_sum + SW'(RND_I)) >>> TW_FRAC;
    im_shf = (im_sum + SW'(RND_I)) >>> TW_FRAC;
    re_res = saturate(re_shf);
    im_res = saturate(im_shf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
      sat       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_vld;
      dout_re   <= s2_vld ? re_res.val : '0;
      dout_im   <= s2_vld ? im_res.val : '0;
      sat       <= s2_vld && (re_res.ovf || im_res.ovf);
    end
  end

endmodule

// File: tb/tb_twiddle_cmult_pipe.sv
// Directed bench for twiddle_cmult_pipe: a rounding instance and a truncating instance share stimulus.
module tb_twiddle_cmult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din_re;
  logic [15:0] din_im;
  logic [7:0]  w_re;
  logic [7:0]  w_im;
  logic        conj;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout_re;
  logic [15:0] dout_im;
  logic        sat;

  logic        t_in_ready;
  logic        t_out_valid;
  logic [15:0] t_dout_re;
  logic [15:0] t_dout_im;
  logic        t_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  twiddle_cmult_pipe #(.DATA_W(16), .TW_W(8), .TW_FRAC(6), .ROUND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din_re(din_re), .din_im(din_im), .w_re(w_re), .w_im(w_im), .conj(conj),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_re(dout_re), .dout_im(dout_im), .sat(sat)
  );

  twiddle_cmult_pipe #(.DATA_W(16), .TW_W(8), .TW_FRAC(6), .ROUND(0)) u_dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .din_re(din_re), .din_im(din_im), .w_re(w_re), .w_im(w_im), .conj(conj),
    .out_valid(t_out_valid), .out_ready(out_ready),
    .dout_re(t_dout_re), .dout_im(t_dout_im), .sat(t_sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated sample; checks the 3-cycle latency and the result.
  task automatic run_one(input string tag, input logic [15:0] are, input logic [15:0] aim,
                         input logic [7:0] wr, input logic [7:0] wi, input logic cj,
                         input logic [15:0] ere, input logic [15:0] eim, input logic es);
    @(negedge clk);
    din_re = are; din_im = aim; w_re = wr; w_im = wi; conj = cj; in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_re"}, 32'(dout_re), 32'(ere));
    check_eq({tag, "_im"}, 32'(dout_im), 32'(eim));
    check_eq({tag, "_sat"}, 32'(sat), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int recv;
    int stall_cnt;
    int seen;
    logic [15:0] exp_im;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din_re = '0; din_im = '0; w_re = '0; w_im = '0; conj = 1'b0;
    #3;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_dout_re", 32'(dout_re), 32'd0);
    check_eq("rst_dout_im", 32'(dout_im), 32'd0);
    check_eq("rst_sat", 32'(sat), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_one("ident",   16'h0400, 16'h0000, 8'h40, 8'h00, 1'b0, 16'h0400, 16'h0000, 1'b0);
    run_one("near1",   16'h0400, 16'h0000, 8'h3F, 8'h00, 1'b0, 16'h03F0, 16'h0000, 1'b0);
    run_one("rot",     16'h0400, 16'h0000, 8'h00, 8'h40, 1'b0, 16'h0000, 16'h0400, 1'b0);
    run_one("rotconj", 16'h0400, 16'h0000, 8'h00, 8'h40, 1'b1, 16'h0000, 16'hFC00, 1'b0);
    run_one("satur",   16'h8000, 16'h8000, 8'hC0, 8'h40, 1'b0, 16'h7FFF, 16'h0000, 1'b1);
    run_one("round",   16'h0001, 16'h0000, 8'h20, 8'h00, 1'b0, 16'h0001, 16'h0000, 1'b0);
    check_eq("trunc_out_valid", 32'(t_out_valid), 32'd1);
    check_eq("trunc_re", 32'(t_dout_re), 32'd0);
    check_eq("trunc_im", 32'(t_dout_im), 32'd0);
    check_eq("trunc_sat", 32'(t_sat), 32'd0);
    check_eq("trunc_in_ready", 32'(t_in_ready), 32'd1);
    // W = -2.0 on both components: (0x0100,0x0080)*(-2-2j) = (-0x0100,-0x0300)
    run_one("wmin",    16'h0100, 16'h0080, 8'h80, 8'h80, 1'b0, 16'hFF00, 16'hFD00, 1'b0);

    // Stream of 5 with alternating conj; stall output for 4 cycles after the first transfer.
    sent = 0; recv = 0; stall_cnt = 0;
    w_re = 8'h00; w_im = 8'h40; din_im = 16'h0000;
    for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(recv == 1 && stall_cnt < 4);
      #1;
      exp_im = 16'(16'h0100 * (recv + 1));
      if (recv % 2 == 1) exp_im = -exp_im;
      if (!out_ready) begin
        stall_cnt++;
        check_eq("bp_stall_valid", 32'(out_valid), 32'd1);
        check_eq("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_stall_im", 32'(dout_im), 32'(exp_im));
      end
      if (out_valid && out_ready) begin
        check_eq("bp_out_im", 32'(dout_im), 32'(exp_im));
        check_eq("bp_out_re", 32'(dout_re), 32'd0);
        recv++;
      end
      if (sent < 5) begin
        in_valid = 1'b1;
        din_re = 16'(16'h0100 * (sent + 1));
        conj = (sent % 2 == 1);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_recv_count", 32'(recv), 32'd5);
    check_eq("bp_stall_cycles", 32'(stall_cnt), 32'd4);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("bp_no_dup", 32'(seen), 32'd0);

    // Reset while samples are in flight.
    w_re = 8'h40; w_im = 8'h00; conj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      din_re = 16'(16'h0300 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mid_out_valid", 32'(out_valid), 32'd1);
    check_eq("mid_dout_re", 32'(dout_re), 32'h0300);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_dout_re", 32'(dout_re), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || t_out_valid) seen++;
    end
    check_eq("rst_no_stale", 32'(seen), 32'd0);

    // Pipeline still works after the mid-stream reset.
    run_one("post_rst", 16'h0200, 16'h0100, 8'h40, 8'h00, 1'b1, 16'h0200, 16'h0100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
